// File: rtl/exception_unit.sv
// exception_unit: commit-stage trap controller feeding the CSR file.
// Collects exception flags, synchronised interrupts and MRET from the
// commit stage. It picks one event, drives the CSR trap-write inputs,
// then sequences a pipeline flush and a fetch redirect handshake.
module exception_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] mem_addr_i,
   input  logic            e_inst_misaligned_i,
   input  logic            e_inst_access_i,
   input  logic            e_illegal_inst_i,
   input  logic            e_illegal_inst_csr_i,
   input  logic            e_breakpoint_i,
   input  logic            e_ecall_i,
   input  logic            e_load_misaligned_i,
   input  logic            e_load_access_i,
   input  logic            e_store_misaligned_i,
   input  logic            e_store_access_i,
   input  logic            is_mret_i,
   input  logic            mstatus_mie_i,
   input  logic [XLEN-1:0] mie_i,
   input  logic            ext_int_i,
   input  logic            timer_int_i,
   input  logic            soft_int_i,
   input  logic            redirect_ack_i,
   output logic            we_exc_o,
   output logic [XLEN-1:0] mcause_d_o,
   output logic [XLEN-1:0] mepc_d_o,
   output logic [XLEN-1:0] mtval_d_o,
   output logic [XLEN-1:0] mip_d_o,
   output logic            is_int_o,
   output logic            sel_exc_nret_o,
   output logic            flush_o,
   output logic            redirect_o,
   output logic            stall_o
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] TRAP     = 2'd1;
   localparam logic [1:0] REDIRECT = 2'd2;

   // Interrupt line order in the synchroniser vectors: {ext, timer, soft}
   logic [2:0]      sync1_q, sync2_q;
   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] tval_q, tval_d;
   logic            isInt_q, isInt_d;
   logic            mret_q, mret_d;
   logic            redirFirst_q, redirFirst_d;

   logic [XLEN-1:0] mipVal;
   logic [XLEN-1:0] pend;
   logic            intAny;
   logic            excAny;
   logic [XLEN-1:0] intCause;
   logic [XLEN-1:0] excCause;
   logic [XLEN-1:0] excTval;

   // Two-flop synchronisers bring the asynchronous interrupt lines into clk_i
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
      end else begin
         sync1_q <= {ext_int_i, timer_int_i, soft_int_i};
         sync2_q <= sync1_q;
      end
   end

   // Build mip from the synchronised lines and work out the interrupt cause
   always_comb begin
      mipVal     = '0;
      mipVal[11] = sync2_q[2];
      mipVal[7]  = sync2_q[1];
      mipVal[3]  = sync2_q[0];
      pend       = mipVal & mie_i & {XLEN{mstatus_mie_i}};
      intAny     = |pend;
      intCause   = '0;
      intCause[XLEN-1] = 1'b1;
      if (pend[11])
         intCause[3:0] = 4'd11;
      else if (pend[3])
         intCause[3:0] = 4'd3;
      else
         intCause[3:0] = 4'd7;
   end

   // Pick the highest-priority exception and the matching trap value
   always_comb begin
      excAny   = e_inst_access_i | e_illegal_inst_i | e_illegal_inst_csr_i |
                 e_inst_misaligned_i | e_breakpoint_i | e_ecall_i |
                 e_store_misaligned_i | e_load_misaligned_i |
                 e_store_access_i | e_load_access_i;
      excCause = '0;
      excTval  = '0;
      if (e_inst_access_i) begin
         excCause[4:0] = 5'd1;
         excTval       = pc_i;
      end else if (e_illegal_inst_i || e_illegal_inst_csr_i) begin
         excCause[4:0] = 5'd2;
         excTval[31:0] = inst_i;
      end else if (e_inst_misaligned_i) begin
         excCause[4:0] = 5'd0;
         excTval       = pc_i;
      end else if (e_breakpoint_i) begin
         excCause[4:0] = 5'd3;
         excTval       = pc_i;
      end else if (e_ecall_i) begin
         excCause[4:0] = 5'd11;
      end else if (e_store_misaligned_i) begin
         excCause[4:0] = 5'd6;
         excTval       = mem_addr_i;
      end else if (e_load_misaligned_i) begin
         excCause[4:0] = 5'd4;
         excTval       = mem_addr_i;
      end else if (e_store_access_i) begin
         excCause[4:0] = 5'd7;
         excTval       = mem_addr_i;
      end else if (e_load_access_i) begin
         excCause[4:0] = 5'd5;
         excTval       = mem_addr_i;
      end
   end

   // Trap sequencer: accept one event in IDLE, write CSRs, then redirect fetch
   always_comb begin
      state_d      = state_q;
      cause_d      = cause_q;
      epc_d        = epc_q;
      tval_d       = tval_q;
      isInt_d      = isInt_q;
      mret_d       = mret_q;
      redirFirst_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_i && (intAny || excAny || is_mret_i)) begin
               epc_d = pc_i;
               if (intAny) begin
                  cause_d = intCause;
                  tval_d  = '0;
                  isInt_d = 1'b1;
                  mret_d  = 1'b0;
                  state_d = TRAP;
               end else if (excAny) begin
                  cause_d = excCause;
                  tval_d  = excTval;
                  isInt_d = 1'b0;
                  mret_d  = 1'b0;
                  state_d = TRAP;
               end else begin
                  cause_d      = '0;
                  tval_d       = '0;
                  isInt_d      = 1'b0;
                  mret_d       = 1'b1;
                  redirFirst_d = 1'b1;
                  state_d      = REDIRECT;
               end
            end
         end
         TRAP: begin
            redirFirst_d = 1'b1;
            state_d      = REDIRECT;
         end
         REDIRECT: begin
            if (redirect_ack_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latched trap information registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cause_q      <= '0;
         epc_q        <= '0;
         tval_q       <= '0;
         isInt_q      <= 1'b0;
         mret_q       <= 1'b0;
         redirFirst_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cause_q      <= cause_d;
         epc_q        <= epc_d;
         tval_q       <= tval_d;
         isInt_q      <= isInt_d;
         mret_q       <= mret_d;
         redirFirst_q <= redirFirst_d;
      end
   end

   // Outputs decoded from the current state; CSR data always shows latched values
   always_comb begin
      we_exc_o       = (state_q == TRAP);
      is_int_o       = (state_q == TRAP) && isInt_q;
      redirect_o     = (state_q == REDIRECT);
      sel_exc_nret_o = (state_q == REDIRECT) && mret_q;
      flush_o        = (state_q == TRAP) ||
                       ((state_q == REDIRECT) && mret_q && redirFirst_q);
      stall_o        = (state_q == TRAP) || (state_q == REDIRECT);
      mcause_d_o     = cause_q;
      mepc_d_o       = epc_q;
      mtval_d_o      = tval_q;
      mip_d_o        = mipVal;
   end

endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: scenario-driven bench for exception_unit.
// Expected trap records are queued when an event is driven and popped when
// the DUT raises its CSR write strobe.
module tb_exception_unit;

   typedef struct packed {
      logic [31:0] cause;
      logic [31:0] epc;
      logic [31:0] tval;
      logic        isInt;
   } trapRec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [31:0] pc, inst, memAddr, mie;
   logic        eInstMis, eInstAcc, eIll, eIllCsr, eBrk, eEcall;
   logic        eLdMis, eLdAcc, eStMis, eStAcc;
   logic        isMret, mstatusMie, extInt, timerInt, softInt, ack;
   logic        weExc, isInt, selExcNret, flush, redirect, stall;
   logic [31:0] mcause, mepc, mtval, mip;

   trapRec_t expQ[$];
   trapRec_t expRec, obsRec;
   int       nChecks = 0;
   int       nFails  = 0;

   exception_unit #(.XLEN(32)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc), .inst_i(inst),
      .mem_addr_i(memAddr),
      .e_inst_misaligned_i(eInstMis), .e_inst_access_i(eInstAcc),
      .e_illegal_inst_i(eIll), .e_illegal_inst_csr_i(eIllCsr),
      .e_breakpoint_i(eBrk), .e_ecall_i(eEcall),
      .e_load_misaligned_i(eLdMis), .e_load_access_i(eLdAcc),
      .e_store_misaligned_i(eStMis), .e_store_access_i(eStAcc),
      .is_mret_i(isMret), .mstatus_mie_i(mstatusMie), .mie_i(mie),
      .ext_int_i(extInt), .timer_int_i(timerInt), .soft_int_i(softInt),
      .redirect_ack_i(ack),
      .we_exc_o(weExc), .mcause_d_o(mcause), .mepc_d_o(mepc),
      .mtval_d_o(mtval), .mip_d_o(mip), .is_int_o(isInt),
      .sel_exc_nret_o(selExcNret), .flush_o(flush),
      .redirect_o(redirect), .stall_o(stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInstr();
      valid = 0; pc = 0; inst = 0; memAddr = 0;
      eInstMis = 0; eInstAcc = 0; eIll = 0; eIllCsr = 0; eBrk = 0;
      eEcall = 0; eLdMis = 0; eLdAcc = 0; eStMis = 0; eStAcc = 0;
      isMret = 0;
   endtask

   task automatic test_reset();
      clearInstr();
      rst = 1; ack = 0; mie = 0; mstatusMie = 0;
      extInt = 0; timerInt = 0; softInt = 0;
      tick(); tick();
      nChecks++;
      if ({weExc, isInt, selExcNret, flush, redirect, stall, mcause, mepc, mtval, mip} !== '0) begin
         nFails++;
         $display("[TB] FAIL reset_outputs: got we=%b int=%b sel=%b fl=%b rd=%b st=%b cause=%h epc=%h tval=%h mip=%h, want all 0",
                  weExc, isInt, selExcNret, flush, redirect, stall, mcause, mepc, mtval, mip);
      end
      rst = 0;
      tick();
   endtask

   task automatic test_illegal();
      valid = 1; pc = 32'h100; inst = 32'hFFFF_FFFF; eIll = 1;
      expQ.push_back('{cause: 32'd2, epc: 32'h100, tval: 32'hFFFF_FFFF, isInt: 1'b0});
      tick();
      clearInstr();
      nChecks++;
      if (weExc !== 1'b1 || flush !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL illegal_strobe: got we=%b flush=%b, want 1 1", weExc, flush);
      end
      expRec = expQ.pop_front();
      obsRec = {mcause, mepc, mtval, isInt};
      nChecks++;
      if (obsRec !== expRec) begin
         nFails++;
         $display("[TB] FAIL illegal_data: got %h, want %h", obsRec, expRec);
      end
      tick();
      nChecks++;
      if ({weExc, redirect, selExcNret, flush, stall} !== 5'b01001) begin
         nFails++;
         $display("[TB] FAIL illegal_redirect: got we/rd/sel/fl/st=%b, want 01001",
                  {weExc, redirect, selExcNret, flush, stall});
      end
      tick();
      nChecks++;
      if (redirect !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL illegal_redirect_hold: got %b, want 1", redirect);
      end
      ack = 1;
      tick();
      ack = 0;
      nChecks++;
      if ({redirect, stall, weExc} !== 3'b000) begin
         nFails++;
         $display("[TB] FAIL illegal_back_idle: got rd/st/we=%b, want 000", {redirect, stall, weExc});
      end
   endtask

   task automatic test_priority();
      // Instruction access beats ecall and load access
      valid = 1; pc = 32'h200; memAddr = 32'h3000;
      eInstAcc = 1; eEcall = 1; eLdAcc = 1;
      expQ.push_back('{cause: 32'd1, epc: 32'h200, tval: 32'h200, isInt: 1'b0});
      tick();
      clearInstr();
      nChecks++;
      if (weExc !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL prio_access_we: got %b, want 1", weExc);
      end
      expRec = expQ.pop_front();
      obsRec = {mcause, mepc, mtval, isInt};
      nChecks++;
      if (obsRec !== expRec) begin
         nFails++;
         $display("[TB] FAIL prio_access_data: got %h, want %h", obsRec, expRec);
      end
      tick(); ack = 1; tick(); ack = 0;

      // Load misaligned on its own
      valid = 1; pc = 32'h204; memAddr = 32'h2003; eLdMis = 1;
      expQ.push_back('{cause: 32'd4, epc: 32'h204, tval: 32'h2003, isInt: 1'b0});
      tick();
      clearInstr();
      expRec = expQ.pop_front();
      obsRec = {mcause, mepc, mtval, isInt};
      nChecks++;
      if (weExc !== 1'b1 || obsRec !== expRec) begin
         nFails++;
         $display("[TB] FAIL prio_ldmis: got we=%b %h, want we=1 %h", weExc, obsRec, expRec);
      end
      tick(); ack = 1; tick(); ack = 0;

      // Store misaligned together with MRET: the exception wins
      valid = 1; pc = 32'h90; memAddr = 32'h5006; eStMis = 1; isMret = 1;
      expQ.push_back('{cause: 32'd6, epc: 32'h90, tval: 32'h5006, isInt: 1'b0});
      tick();
      clearInstr();
      expRec = expQ.pop_front();
      obsRec = {mcause, mepc, mtval, isInt};
      nChecks++;
      if (weExc !== 1'b1 || obsRec !== expRec) begin
         nFails++;
         $display("[TB] FAIL exc_over_mret: got we=%b %h, want we=1 %h", weExc, obsRec, expRec);
      end
      tick();
      nChecks++;
      if ({redirect, selExcNret} !== 2'b10) begin
         nFails++;
         $display("[TB] FAIL exc_over_mret_sel: got rd/sel=%b, want 10", {redirect, selExcNret});
      end
      ack = 1; tick(); ack = 0;
   endtask

   task automatic test_timer_int();
      mie = 32'h80; mstatusMie = 1; timerInt = 1;
      tick();
      nChecks++;
      if (mip !== 32'h0) begin
         nFails++;
         $display("[TB] FAIL timer_sync1: got mip=%h, want 0", mip);
      end
      tick();
      nChecks++;
      if (mip !== 32'h80) begin
         nFails++;
         $display("[TB] FAIL timer_sync2: got mip=%h, want 00000080", mip);
      end
      valid = 1; pc = 32'h40; inst = 32'h1234_5678;
      expQ.push_back('{cause: 32'h8000_0007, epc: 32'h40, tval: 32'h0, isInt: 1'b1});
      tick();
      clearInstr();
      expRec = expQ.pop_front();
      obsRec = {mcause, mepc, mtval, isInt};
      nChecks++;
      if (weExc !== 1'b1 || obsRec !== expRec) begin
         nFails++;
         $display("[TB] FAIL timer_trap: got we=%b %h, want we=1 %h", weExc, obsRec, expRec);
      end
      tick(); ack = 1; tick(); ack = 0;

      // Globally disabled: line still visible in mip, never taken
      mstatusMie = 0;
      valid = 1; pc = 32'h44;
      tick();
      clearInstr();
      nChecks++;
      if ({weExc, stall, redirect} !== 3'b000 || mip !== 32'h80) begin
         nFails++;
         $display("[TB] FAIL timer_disabled: got we/st/rd=%b mip=%h, want 000 00000080",
                  {weExc, stall, redirect}, mip);
      end
      timerInt = 0; mie = 0; mstatusMie = 1;
      tick(); tick(); tick();
   endtask

   task automatic test_mret();
      valid = 1; pc = 32'h80; isMret = 1;
      tick();
      clearInstr();
      nChecks++;
      if ({weExc, redirect, selExcNret, flush, stall} !== 5'b01111) begin
         nFails++;
         $display("[TB] FAIL mret_first: got we/rd/sel/fl/st=%b, want 01111",
                  {weExc, redirect, selExcNret, flush, stall});
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         nChecks++;
         if ({weExc, redirect, selExcNret, flush, stall} !== 5'b01101) begin
            nFails++;
            $display("[TB] FAIL mret_hold%0d: got we/rd/sel/fl/st=%b, want 01101",
                     i, {weExc, redirect, selExcNret, flush, stall});
         end
      end
      ack = 1;
      tick();
      ack = 0;
      nChecks++;
      if ({redirect, stall, selExcNret} !== 3'b000) begin
         nFails++;
         $display("[TB] FAIL mret_idle: got rd/st/sel=%b, want 000", {redirect, stall, selExcNret});
      end
   endtask

   task automatic test_simultaneous();
      mie = 32'h888; mstatusMie = 1; extInt = 1; softInt = 1;
      tick(); tick();
      nChecks++;
      if (mip !== 32'h808) begin
         nFails++;
         $display("[TB] FAIL simul_mip: got %h, want 00000808", mip);
      end
      valid = 1; pc = 32'h300; eEcall = 1;
      expQ.push_back('{cause: 32'h8000_000B, epc: 32'h300, tval: 32'h0, isInt: 1'b1});
      tick();
      clearInstr();
      extInt = 0; softInt = 0;
      expRec = expQ.pop_front();
      obsRec = {mcause, mepc, mtval, isInt};
      nChecks++;
      if (weExc !== 1'b1 || obsRec !== expRec) begin
         nFails++;
         $display("[TB] FAIL simul_trap: got we=%b %h, want we=1 %h", weExc, obsRec, expRec);
      end
      tick();
      // An exception arriving during REDIRECT must be ignored
      valid = 1; pc = 32'h400; eIll = 1; inst = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         tick();
         nChecks++;
         if ({weExc, redirect} !== 2'b01) begin
            nFails++;
            $display("[TB] FAIL simul_ignore%0d: got we/rd=%b, want 01", i, {weExc, redirect});
         end
      end
      clearInstr();
      ack = 1;
      tick();
      ack = 0;
      tick();
      nChecks++;
      if ({weExc, stall, mcause} !== {2'b00, 32'h8000_000B}) begin
         nFails++;
         $display("[TB] FAIL simul_after: got we=%b st=%b cause=%h, want 0 0 8000000b",
                  weExc, stall, mcause);
      end
      mie = 0;
      tick();
   endtask

   task automatic test_reset_in_trap();
      valid = 1; pc = 32'h500; eEcall = 1;
      expQ.push_back('{cause: 32'd11, epc: 32'h500, tval: 32'h0, isInt: 1'b0});
      tick();
      clearInstr();
      expRec = expQ.pop_front();
      obsRec = {mcause, mepc, mtval, isInt};
      nChecks++;
      if (weExc !== 1'b1 || obsRec !== expRec) begin
         nFails++;
         $display("[TB] FAIL rst_trap_pre: got we=%b %h, want we=1 %h", weExc, obsRec, expRec);
      end
      rst = 1;
      tick();
      nChecks++;
      if ({weExc, isInt, selExcNret, flush, redirect, stall, mcause, mepc, mtval, mip} !== '0) begin
         nFails++;
         $display("[TB] FAIL rst_trap_outputs: got we=%b fl=%b rd=%b st=%b cause=%h epc=%h, want all 0",
                  weExc, flush, redirect, stall, mcause, mepc);
      end
      rst = 0;
      tick();
      nChecks++;
      if ({weExc, redirect, stall} !== 3'b000) begin
         nFails++;
         $display("[TB] FAIL rst_trap_no_redirect: got we/rd/st=%b, want 000", {weExc, redirect, stall});
      end
   endtask

   initial begin
      test_reset();
      test_illegal();
      test_priority();
      test_timer_int();
      test_mret();
      test_simultaneous();
      test_reset_in_trap();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Commit-stage trap controller that sits directly upstream of the CSR file.
- Collects per-instruction exception flags, synchronised interrupt lines and MRET from the commit stage.
- Prioritises them, then drives the CSR trap-write inputs (we_exc, mcause/mepc/mtval/mip data, is_int, sel_exc_nret).
- Sequences pipeline flush and PC redirect with a handshake to fetch. The redirect target is the CSR's exc_ret_addr output (mtvec or mepc).

Parameters:
XLEN, 32, datapath width for pc/addr/CSR data.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
valid_i  in  1  instruction at commit is valid
pc_i  in  XLEN  PC of committing instruction
inst_i  in  32  instruction word (mtval for illegal)
mem_addr_i  in  XLEN  load/store effective address
e_inst_misaligned_i, e_inst_access_i, e_illegal_inst_i, e_illegal_inst_csr_i, e_breakpoint_i, e_ecall_i, e_load_misaligned_i, e_load_access_i, e_store_misaligned_i, e_store_access_i  in  1 each  exception flags, qualified by valid_i
is_mret_i  in  1  committing instruction is MRET
mstatus_mie_i  in  1  mstatus.MIE from CSR
mie_i  in  XLEN  mie register from CSR
ext_int_i, timer_int_i, soft_int_i  in  1 each  asynchronous interrupt lines
redirect_ack_i  in  1  fetch accepted redirect
we_exc_o  out  1  CSR trap write strobe
mcause_d_o, mepc_d_o, mtval_d_o, mip_d_o  out  XLEN  CSR write data
is_int_o  out  1  trap is an interrupt
sel_exc_nret_o  out  1  1 = redirect to mepc (MRET), 0 = mtvec
flush_o  out  1  kill younger pipeline instructions
redirect_o  out  1  fetch must load CSR exc_ret_addr
stall_o  out  1  hold commit stage

Behaviour:
- Reset values: state IDLE; all outputs 0; synchroniser flops and latched cause/epc/tval at 0.
- Interrupt inputs:
  - Each line passes through a 2-flop synchroniser (2-cycle latency).
  - mip_d_o is continuous: bit11=meip, bit7=mtip, bit3=msip, all other bits 0.
  - pend = mip_d_o & mie_i, gated by mstatus_mie_i.
- Exception cause priority, highest first:
  - inst_access=1
  - illegal (either flag)=2
  - inst_misaligned=0
  - breakpoint=3
  - ecall=11
  - store_misaligned=6
  - load_misaligned=4
  - store_access=7
  - load_access=5
- Interrupt cause priority: ext=11 > soft=3 > timer=7. mcause bit31=1 for interrupts, 0 for exceptions.
- Event arbitration: interrupt > exception > MRET.
- mtval values:
  - illegal: inst_i
  - inst misaligned/access and breakpoint: pc_i
  - load/store misaligned/access: mem_addr_i
  - ecall and interrupts: 0
- mepc = pc_i in all cases. For an interrupt, the instruction at commit is not retired.
- FSM states:
  - IDLE: if valid_i and any event, latch cause/epc/tval/is_int and the MRET flag. Then go to TRAP for exception/interrupt, or REDIRECT for MRET. Otherwise stay in IDLE. stall_o=0.
  - TRAP (exactly 1 cycle): we_exc_o=1, is_int_o=latched, flush_o=1, stall_o=1, data outputs show latched values. Then go to REDIRECT.
  - REDIRECT: redirect_o=1, stall_o=1, sel_exc_nret_o=latched MRET flag. flush_o=1 on the first REDIRECT cycle of an MRET. Hold until redirect_ack_i=1, then go to IDLE on the next edge.
- Trap latency: event accepted in cycle N; we_exc_o in N+1; redirect_o from N+2.
- Data outputs mcause/mepc/mtval hold latched values outside TRAP. we_exc_o=0 outside TRAP.
- Outside IDLE, valid_i and all exception flags are ignored. An interrupt arising then stays pending and is taken on the first valid_i in IDLE.
- Exception and MRET in the same instruction: the exception wins and MRET is dropped.
- Interrupt disabled via mstatus_mie_i or mie_i: never taken, but mip_d_o still reflects the lines.
- redirect_ack_i already high on the first REDIRECT cycle: one-cycle REDIRECT.
- rst_i in any state: next cycle IDLE with all outputs 0. An in-flight trap is abandoned with no we_exc_o.

Test Plan:
- Illegal instruction: valid_i=1, pc_i=0x100, inst_i=0xFFFFFFFF, e_illegal_inst_i=1 -> next cycle we_exc_o=1, mcause_d_o=2, mepc_d_o=0x100, mtval_d_o=0xFFFFFFFF, flush_o=1. Following cycle redirect_o=1, sel_exc_nret_o=0 until ack.
- Priority: e_inst_access_i, e_ecall_i and e_load_access_i all set -> mcause_d_o=1, mtval_d_o=pc_i. Load misaligned alone at mem_addr_i=0x2003 -> mcause=4, mtval=0x2003.
- Timer interrupt: mie_i=0x80, mstatus_mie_i=1, timer_int_i rises -> mip_d_o=0x80 two cycles later. Next valid_i at pc 0x40 -> mcause_d_o=0x80000007, is_int_o=1, mepc=0x40, mtval=0. Repeat with mstatus_mie_i=0 -> no trap.
- MRET: is_mret_i=1 -> no we_exc_o, redirect_o=1 with sel_exc_nret_o=1. redirect_ack_i delayed 3 cycles -> redirect_o and stall_o held 3 cycles, then IDLE.
- Simultaneous: ext and soft interrupts plus e_ecall_i in the same instruction -> mcause=0x8000000B. A second exception presented during REDIRECT is ignored.
- Reset in TRAP state -> next cycle all outputs 0, state IDLE, no redirect issued.
